// File: rtl/ex_muldiv.sv
// RV32 M-extension execute unit: one-cycle multiply, 32-cycle restoring divide.
// Flush aborts in-flight work; results are held until the next completion.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_q;
  logic [31:0] r_rem;
  logic [31:0] r_result;
  logic [4:0]  r_cnt;
  logic [4:0]  r_rd;
  logic [4:0]  r_rd_o;
  logic [2:0]  r_f3;

  logic        w_mop;
  logic        w_start;
  logic        w_dz;
  logic        w_ovf;
  logic        w_special;
  logic [31:0] w_spec_res;
  logic [31:0] w_in_a_mag;
  logic        w_load;
  logic [31:0] w_res;

  assign w_mop   = (opcode_i == 7'b0110011)
                 & (funct7_i == 7'b0000001);
  assign w_start = valid_i & w_mop & ~flush_i
                 & (r_state == S_IDLE);

  assign w_dz  = (rs2_data_i == 32'h0);
  assign w_ovf = ~funct3_i[0]
               & (rs1_data_i == 32'h8000_0000)
               & (rs2_data_i == 32'hFFFF_FFFF);
  assign w_special = funct3_i[2] & (w_dz | w_ovf);

  always_comb begin
    w_spec_res = 32'h8000_0000;
    if (w_dz)
      w_spec_res = funct3_i[1] ? rs1_data_i
                               : 32'hFFFF_FFFF;
    else if (funct3_i[1])
      w_spec_res = 32'h0;
  end

  assign w_in_a_mag = (~funct3_i[0] & rs1_data_i[31])
                    ? (32'h0 - rs1_data_i)
                    : rs1_data_i;

  // Multiply: 33-bit extended operands, product taken mod 2^64
  logic        w_a_ext;
  logic        w_b_ext;
  logic [63:0] w_a64;
  logic [63:0] w_b64;
  logic [63:0] w_prod;
  logic [31:0] w_mul_res;

  assign w_a_ext = r_a[31] & (r_f3[1] ^ r_f3[0]);
  assign w_b_ext = r_b[31] & (r_f3[1:0] == 2'b01);
  assign w_a64   = {{31{w_a_ext}}, w_a_ext, r_a};
  assign w_b64   = {{31{w_b_ext}}, w_b_ext, r_b};
  assign w_prod  = w_a64 * w_b64;
  assign w_mul_res = (r_f3[1:0] == 2'b00)
                   ? w_prod[31:0]
                   : w_prod[63:32];

  logic        w_sgn;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_b_mag;
  logic [32:0] w_diff;
  logic        w_qbit;
  logic [31:0] w_rem_nx;
  logic [31:0] w_q_nx;
  logic [31:0] w_quo_f;
  logic [31:0] w_rem_f;
  logic [31:0] w_div_res;

  assign w_sgn   = ~r_f3[0];
  assign w_a_neg = w_sgn & r_a[31];
  assign w_b_neg = w_sgn & r_b[31];
  assign w_b_mag = w_b_neg ? (32'h0 - r_b) : r_b;

  // r_q shifts dividend bits out the top and quotient bits in the bottom
  assign w_diff   = {r_rem, r_q[31]} - {1'b0, w_b_mag};
  assign w_qbit   = ~w_diff[32];
  assign w_rem_nx = w_qbit ? w_diff[31:0]
                           : {r_rem[30:0], r_q[31]};
  assign w_q_nx   = {r_q[30:0], w_qbit};

  assign w_quo_f = (w_a_neg ^ w_b_neg)
                 ? (32'h0 - w_q_nx) : w_q_nx;
  assign w_rem_f = w_a_neg
                 ? (32'h0 - w_rem_nx) : w_rem_nx;
  assign w_div_res = r_f3[1] ? w_rem_f : w_quo_f;

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_res  = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_special) begin
            w_next = S_DONE;
            w_load = 1'b1;
            w_res  = w_spec_res;
          end else if (funct3_i[2]) begin
            w_next = S_DIV;
          end else begin
            w_next = S_MUL;
          end
        end
      end
      S_MUL: begin
        w_next = S_DONE;
        w_load = 1'b1;
        w_res  = w_mul_res;
      end
      S_DIV: begin
        if (r_cnt == 5'd31) begin
          w_next = S_DONE;
          w_load = 1'b1;
          w_res  = w_div_res;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush_i) begin
      w_next = S_IDLE;
      w_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= 32'h0;
      r_b      <= 32'h0;
      r_q      <= 32'h0;
      r_rem    <= 32'h0;
      r_result <= 32'h0;
      r_cnt    <= 5'd0;
      r_rd     <= 5'd0;
      r_rd_o   <= 5'd0;
      r_f3     <= 3'd0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_a   <= rs1_data_i;
        r_b   <= rs2_data_i;
        r_f3  <= funct3_i;
        r_rd  <= rd_i;
        r_q   <= w_in_a_mag;
        r_rem <= 32'h0;
        r_cnt <= 5'd0;
      end else if (flush_i) begin
        r_cnt <= 5'd0;
      end else if (r_state == S_DIV) begin
        r_q   <= w_q_nx;
        r_rem <= w_rem_nx;
        r_cnt <= r_cnt + 5'd1;
      end
      if (w_load) begin
        r_result <= w_res;
        r_rd_o   <= (r_state == S_IDLE) ? rd_i : r_rd;
      end
    end
  end

  assign busy_o   = w_start
                  | (r_state == S_MUL)
                  | (r_state == S_DIV);
  assign done_o   = (r_state == S_DONE);
  assign result_o = r_result;
  assign rd_o     = r_rd_o;

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameters: none; all widths are fixed at RV32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 valid_i  input  1  the ID/EX register holds a valid instruction this cycle.
REQ-005 opcode_i  input  7  opcode from the ID/EX register.
REQ-006 funct3_i  input  3  funct3 from the ID/EX register; selects the M-extension operation.
REQ-007 funct7_i  input  7  funct7 from the ID/EX register.
REQ-008 rs1_data_i  input  32  operand A (multiplicand or dividend).
REQ-009 rs2_data_i  input  32  operand B (multiplier or divisor).
REQ-010 rd_i  input  5  destination register index.
REQ-011 flush_i  input  1  kill any in-flight operation; highest priority after reset.
REQ-012 busy_o  output  1  stall request to the IF/ID and ID/EX registers.
REQ-013 done_o  output  1  one-cycle pulse; result_o and rd_o are valid.
REQ-014 result_o  output  32  operation result, held until the next done_o or reset.
REQ-015 rd_o  output  5  latched destination index, held with result_o.

Function
REQ-016 M op: opcode_i==7'b0110011 and funct7_i==7'b0000001; start = valid_i & M op & ~flush_i & (state==IDLE).
REQ-017 funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU; results are per the RISC-V M specification.
REQ-018 FSM states: IDLE, MUL, DIV, DONE; on start, operands, rd_i and funct3_i are latched.
REQ-019 IDLE->MUL on start with funct3[2]==0; IDLE->DIV on start with funct3[2]==1, except for special cases (REQ-024, REQ-025); IDLE->DONE on start with a special case.
REQ-020 MUL: 33x33 signed product of the sign- or zero-extended operands, completed in one cycle; MUL returns bits [31:0], MULH/MULHSU/MULHU return bits [63:32]; MUL->DONE.
REQ-021 DIV: unsigned restoring division of the operand magnitudes, 1 quotient bit per cycle, 5-bit counter 0..31; DIV->DONE after the 32nd iteration.
REQ-022 Signed fixup: the quotient is negated when the operand signs differ (DIV); the remainder takes the dividend's sign (REM).
REQ-023 Latency, with start sampled at the edge ending cycle T: MUL ops assert done_o in cycle T+2; divide ops in T+33; special cases in T+1.
REQ-024 Divide by zero (rs2==0): DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
REQ-025 Signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
REQ-026 DONE lasts exactly one cycle with done_o=1, updates result_o and rd_o, and then goes to IDLE.
REQ-027 No start is accepted in DONE; the next op is accepted in IDLE the following cycle (back-to-back gap of 1 cycle).
REQ-028 busy_o = start (combinational, in IDLE) | state∈{MUL, DIV}; busy_o=0 in DONE, so the ID/EX register advances at the end of DONE.
REQ-029 flush_i=1 in any state: next state is IDLE, no done_o, result_o and rd_o unchanged; in IDLE, flush_i suppresses start.
REQ-030 Non-M ops, or valid_i=0: no state change, busy_o=0.
REQ-031 rd_i==0 executes normally and pulses done_o; writeback discards the result.

Reset
REQ-032 rst_n low, asynchronously: state=IDLE, counter=0, busy_o=0, done_o=0, result_o=0, rd_o=0, latched operands=0.
REQ-033 Reset during MUL or DIV aborts the operation; no done_o is produced after release.

Verification
REQ-034 MUL rs1=7, rs2=0xFFFFFFFD, rd=5 -> done_o in T+2, result_o=0xFFFFFFEB, rd_o=5, busy_o high in T and T+1 only.
REQ-035 rs1=rs2=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
REQ-036 DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF, each with done_o in T+33 and busy_o high T..T+32; DIVU 100/7 -> 14, REMU 100/7 -> 2.
REQ-037 Special cases: DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, both in T+1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
REQ-038 flush_i in T+10 of a DIV -> IDLE next cycle, busy_o=0, no done_o; funct7=0 with opcode 0110011 -> busy_o never asserted.
REQ-039 rst_n low in T+5 of a DIV -> all outputs 0 immediately; after release, idle with no done_o; a subsequent MUL completes normally.
